// File: rtl/input_debouncer.sv
// Synchronises a raw bouncy input and commits a level change only after
// DEBOUNCE_CYCLES consecutive agreeing samples; also emits edge pulses and a rise count.
`timescale 1ps/1ps
module input_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_raw,
    output logic             X,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] rise_count
);

    localparam int CNT_BITS = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2) begin : g_bad_params
        $error("input_debouncer: SYNC_STAGES and DEBOUNCE_CYCLES must both be at least 2");
    end

    typedef enum logic [1:0] {
        S_LOW,
        S_RISE_WAIT,
        S_HIGH,
        S_FALL_WAIT
    } state_t;

    logic [SYNC_STAGES-1:0] sync_chain_q, sync_chain_d;
    logic                   sync_q;
    state_t                 state_q, state_d;
    logic [CNT_BITS-1:0]    cnt_q, cnt_d;
    logic                   x_q, x_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [CNT_W-1:0]       rise_count_q, rise_count_d;

    assign sync_chain_d = {sync_chain_q[SYNC_STAGES-2:0], btn_raw};
    assign sync_q       = sync_chain_q[SYNC_STAGES-1];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rise_d       = 1'b0;
        fall_d       = 1'b0;
        rise_count_d = rise_count_q;
        unique case (state_q)
            S_LOW: begin
                if (sync_q) begin
                    state_d = S_RISE_WAIT;
                    cnt_d   = CNT_BITS'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            S_RISE_WAIT: begin
                // Any low sample throws away the partial qualification.
                if (!sync_q) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = S_HIGH;
                    cnt_d        = '0;
                    rise_d       = 1'b1;
                    rise_count_d = rise_count_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_BITS'(1);
                end
            end
            S_HIGH: begin
                if (!sync_q) begin
                    state_d = S_FALL_WAIT;
                    cnt_d   = CNT_BITS'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            S_FALL_WAIT: begin
                if (sync_q) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_BITS'(1);
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase
        // X is a registered copy of the committed level, so it moves with the state.
        x_d = (state_d == S_HIGH) || (state_d == S_FALL_WAIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_chain_q <= '0;
            state_q      <= S_LOW;
            cnt_q        <= '0;
            x_q          <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            rise_count_q <= '0;
        end else begin
            sync_chain_q <= sync_chain_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            x_q          <= x_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            rise_count_q <= rise_count_d;
        end
    end

    assign X          = x_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign rise_count = rise_count_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer: default instance plus a CNT_W=2 instance
// sharing the same stimulus to exercise rise_count wrap-around.
`timescale 1ps/1ps
module tb_input_debouncer;

    logic       clk;
    logic       reset;
    logic       btn_raw;
    logic       X, rise, fall;
    logic [7:0] rise_count;
    logic       X_w, rise_w, fall_w;
    logic [1:0] rise_count_w;

    int vecs;
    int errs;

    input_debouncer dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw),
        .X(X), .rise(rise), .fall(fall), .rise_count(rise_count)
    );

    input_debouncer #(.CNT_W(2)) dut_w (
        .clk(clk), .reset(reset), .btn_raw(btn_raw),
        .X(X_w), .rise(rise_w), .fall(fall_w), .rise_count(rise_count_w)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic apply_reset();
        reset   = 1'b1;
        btn_raw = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        btn_raw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) reset = 1'b0;
            @(negedge clk);
            vecs++;
            if ({X, rise, fall} !== 3'b000 || rise_count !== 8'd0) begin
                errs++;
                $display("FAIL reset_idle cyc=%0d X/rise/fall=%b count=%0d required 000 count=0",
                         i, {X, rise, fall}, rise_count);
            end
        end
    endtask

    task automatic test_clean_rise_fall();
        logic ex, er, ef;
        apply_reset();
        for (int i = 0; i < 32; i++) begin
            btn_raw = (i < 20);
            @(negedge clk);
            ex = (i >= 5) && (i < 25);
            er = (i == 5);
            ef = (i == 25);
            vecs++;
            if (X !== ex || rise !== er || fall !== ef) begin
                errs++;
                $display("FAIL clean_edge i=%0d X/rise/fall=%b%b%b required %b%b%b",
                         i, X, rise, fall, ex, er, ef);
            end
        end
        vecs++;
        if (rise_count !== 8'd1) begin
            errs++;
            $display("FAIL clean_count got=%0d required=1", rise_count);
        end
    endtask

    task automatic test_glitch();
        logic ex, er, ef;
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            btn_raw = (i < 3);
            @(negedge clk);
            vecs++;
            if ({X, rise, fall} !== 3'b000) begin
                errs++;
                $display("FAIL glitch3 i=%0d X/rise/fall=%b required 000", i, {X, rise, fall});
            end
        end
        vecs++;
        if (rise_count !== 8'd0) begin
            errs++;
            $display("FAIL glitch3_count got=%0d required=0", rise_count);
        end
        for (int i = 0; i < 14; i++) begin
            btn_raw = (i < 4);
            @(negedge clk);
            ex = (i >= 5) && (i < 9);
            er = (i == 5);
            ef = (i == 9);
            vecs++;
            if (X !== ex || rise !== er || fall !== ef) begin
                errs++;
                $display("FAIL pulse4 i=%0d X/rise/fall=%b%b%b required %b%b%b",
                         i, X, rise, fall, ex, er, ef);
            end
        end
        vecs++;
        if (rise_count !== 8'd1) begin
            errs++;
            $display("FAIL pulse4_count got=%0d required=1", rise_count);
        end
    endtask

    task automatic test_bounce();
        logic [4:0] pat;
        logic       ex, er;
        pat = 5'b01011;  // bit i is the level before edge k+i: 1,1,0,1,0
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            btn_raw = (i < 5) ? pat[i] : 1'b1;
            @(negedge clk);
            ex = (i >= 10);
            er = (i == 10);
            vecs++;
            if (X !== ex || rise !== er || fall !== 1'b0) begin
                errs++;
                $display("FAIL bounce i=%0d X/rise/fall=%b%b%b required %b%b0",
                         i, X, rise, fall, ex, er);
            end
        end
        vecs++;
        if (rise_count !== 8'd1) begin
            errs++;
            $display("FAIL bounce_count got=%0d required=1", rise_count);
        end
    endtask

    task automatic test_wrap();
        logic [1:0] exp_w [5];
        exp_w = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        apply_reset();
        for (int p = 0; p < 5; p++) begin
            btn_raw = 1'b1;
            repeat (8) @(negedge clk);
            btn_raw = 1'b0;
            repeat (8) @(negedge clk);
            vecs++;
            if (rise_count_w !== exp_w[p]) begin
                errs++;
                $display("FAIL wrap_count press=%0d got=%0d required=%0d", p, rise_count_w, exp_w[p]);
            end
            vecs++;
            if (rise_count !== 8'(p + 1)) begin
                errs++;
                $display("FAIL wide_count press=%0d got=%0d required=%0d", p, rise_count, p + 1);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        logic ex, er;
        apply_reset();
        btn_raw = 1'b1;
        repeat (4) @(negedge clk);  // after edge k+3: RISE_WAIT, cnt=2
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vecs++;
        if ({X, rise, fall} !== 3'b000 || rise_count !== 8'd0) begin
            errs++;
            $display("FAIL midwait_reset X/rise/fall=%b count=%0d required 000 count=0",
                     {X, rise, fall}, rise_count);
        end
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            ex = (j >= 5);
            er = (j == 5);
            vecs++;
            if (X !== ex || rise !== er || fall !== 1'b0) begin
                errs++;
                $display("FAIL midwait_requal j=%0d X/rise/fall=%b%b%b required %b%b0",
                         j, X, rise, fall, ex, er);
            end
        end
        vecs++;
        if (rise_count !== 8'd1) begin
            errs++;
            $display("FAIL midwait_count got=%0d required=1", rise_count);
        end
    endtask

    task automatic test_reset_on_commit();
        apply_reset();
        btn_raw = 1'b1;
        repeat (5) @(negedge clk);  // next edge would be the commit edge k+5
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        btn_raw = 1'b0;
        vecs++;
        if ({X, rise, fall} !== 3'b000 || rise_count !== 8'd0) begin
            errs++;
            $display("FAIL commit_reset X/rise/fall=%b count=%0d required 000 count=0",
                     {X, rise, fall}, rise_count);
        end
        repeat (8) @(negedge clk);
        vecs++;
        if ({X, rise, fall} !== 3'b000 || rise_count !== 8'd0) begin
            errs++;
            $display("FAIL commit_after X/rise/fall=%b count=%0d required 000 count=0",
                     {X, rise, fall}, rise_count);
        end
    endtask

    initial begin
        vecs    = 0;
        errs    = 0;
        reset   = 1'b1;
        btn_raw = 1'b0;
        @(negedge clk);
        test_reset();
        test_clean_rise_fall();
        test_glitch();
        test_bounce();
        test_wrap();
        test_reset_mid_wait();
        test_reset_on_commit();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
